// File: rtl/ad_ip_jesd204_tpl_adc_pn_scan.sv
// ad_ip_jesd204_tpl_adc_pn_scan: sequenced per-channel PN lock/error scan with regmap pass-through
module ad_ip_jesd204_tpl_adc_pn_scan #(
  parameter int NUM_CHANNELS  = 1,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int DWELL_CYCLES  = 4096
) (
  input  logic                      link_clk,
  input  logic                      adc_rst,
  input  logic                      start,
  input  logic [3:0]                pn_sel,
  input  logic [NUM_CHANNELS-1:0]   enable,
  input  logic [NUM_CHANNELS*4-1:0] pn_seq_sel_in,
  output logic [NUM_CHANNELS*4-1:0] pn_seq_sel,
  input  logic [NUM_CHANNELS-1:0]   pn_err,
  input  logic [NUM_CHANNELS-1:0]   pn_oos,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_CHANNELS-1:0]   ch_pass,
  output logic [NUM_CHANNELS-1:0]   ch_lock_fail,
  output logic [NUM_CHANNELS*8-1:0] ch_err_cnt
);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  typedef enum logic [2:0] {IDLE, APPLY, LOCK, DWELL, NEXT, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] ch;
  logic [31:0] cnt;
  logic override;
  logic [7:0] err_cnt [NUM_CHANNELS];
  logic [7:0] err_nxt;
  logic hit, last_ch, settle_end, lock_end, dwell_end;
  assign hit        = pn_err[ch] | pn_oos[ch];
  assign err_nxt    = err_cnt[ch] + 8'(hit && err_cnt[ch] != 8'hff);
  assign last_ch    = ch == CW'(NUM_CHANNELS - 1);
  assign settle_end = cnt == 32'(SETTLE_CYCLES - 1);
  assign lock_end   = cnt == 32'(LOCK_TIMEOUT - 1);
  assign dwell_end  = cnt == 32'(DWELL_CYCLES - 1);
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  // state register
  always_ff @(posedge link_clk) state <= adc_rst ? IDLE : state_nxt;
  // next-state: disabled channels skip straight to NEXT, unlocked channels give up after the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? APPLY : IDLE;
      APPLY:   state_nxt = !enable[ch] ? NEXT : settle_end ? LOCK : APPLY;
      LOCK:    state_nxt = !pn_oos[ch] ? DWELL : lock_end ? NEXT : LOCK;
      DWELL:   state_nxt = dwell_end ? NEXT : DWELL;
      NEXT:    state_nxt = last_ch ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // datapath: the shared counter restarts on every state change, results update per phase
  always_ff @(posedge link_clk) begin
    if (adc_rst) begin
      ch           <= '0;
      cnt          <= '0;
      override     <= 1'b0;
      ch_pass      <= '0;
      ch_lock_fail <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) err_cnt[i] <= '0;
    end else begin
      cnt <= state_nxt != state ? '0 : cnt + 32'd1;
      case (state)
        IDLE: if (start) begin
          ch           <= '0;
          ch_pass      <= '0;
          ch_lock_fail <= '0;
          for (int i = 0; i < NUM_CHANNELS; i++) err_cnt[i] <= '0;
        end
        APPLY: override <= enable[ch];
        LOCK: if (pn_oos[ch] && lock_end) ch_lock_fail[ch] <= 1'b1;
        DWELL: begin
          err_cnt[ch] <= err_nxt;
          if (dwell_end) ch_pass[ch] <= err_nxt == 8'd0;
        end
        NEXT: begin
          override <= 1'b0;
          if (!last_ch) ch <= ch + CW'(1);
        end
        default: ;
      endcase
    end
  end
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign pn_seq_sel[i*4 +: 4] = override && ch == CW'(i) ? pn_sel : pn_seq_sel_in[i*4 +: 4];
    assign ch_err_cnt[i*8 +: 8] = err_cnt[i];
  end
endmodule

// File: doc/ad_ip_jesd204_tpl_adc_pn_scan.md
# ad_ip_jesd204_tpl_adc_pn_scan

Link-clock-domain sequencer that runs an automatic PN-sequence integrity scan across all ADC channels of the JESD204 transport layer. It sits between the register map's per-channel `pn_seq_sel` outputs and the TPL datapath PN monitors. On a start pulse it overrides one channel at a time, waits for monitor lock, counts errors over a fixed dwell window, and reports per-channel results. When idle, the regmap PN selections pass through unchanged.

## Interface
Parameters:
- `NUM_CHANNELS`, 1: number of ADC channels scanned.
- `SETTLE_CYCLES`, 16: cycles (≥1) held after applying the override before lock checking starts.
- `LOCK_TIMEOUT`, 1024: maximum cycles (≥1) spent waiting for `pn_oos` to deassert.
- `DWELL_CYCLES`, 4096: error-count window length in cycles (≥1).

Ports:
- `link_clk`  in  1  single clock; all logic is on its rising edge.
- `adc_rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  scan request; sampled only in IDLE.
- `pn_sel`  in  4  PN pattern code applied to the channel under test.
- `enable`  in  NUM_CHANNELS  channel enables; a disabled channel is skipped.
- `pn_seq_sel_in`  in  NUM_CHANNELS*4  pattern selections from the regmap.
- `pn_seq_sel`  out  NUM_CHANNELS*4  pattern selections to the datapath.
- `pn_err`  in  NUM_CHANNELS  per-channel PN error flags.
- `pn_oos`  in  NUM_CHANNELS  per-channel out-of-sync flags.
- `busy`  out  1  high from the cycle after start is accepted through DONE.
- `done`  out  1  one-cycle pulse at scan end.
- `ch_pass`  out  NUM_CHANNELS  channel locked and counted 0 errors.
- `ch_lock_fail`  out  NUM_CHANNELS  channel did not lock within LOCK_TIMEOUT.
- `ch_err_cnt`  out  NUM_CHANNELS*8  per-channel error count, saturating at 255.

## Operation
- FSM states: IDLE, APPLY, LOCK, DWELL, NEXT, DONE. A channel index `ch` has width max(1, clog2(NUM_CHANNELS)). A shared cycle counter `cnt` is 32 bits.
- IDLE: if `start`=1, clear all result vectors, set `ch`=0, and go to APPLY. No override is active.
- APPLY:
  - If `enable[ch]`=0, go to NEXT immediately and leave that channel's results at 0.
  - Otherwise set the override for `ch`, hold for SETTLE_CYCLES cycles, then go to LOCK with `cnt`=0.
- LOCK:
  - If `pn_oos[ch]`=0, go to DWELL with `cnt`=0.
  - Otherwise, when `cnt` reaches LOCK_TIMEOUT-1, set `ch_lock_fail[ch]`=1 and go to NEXT.
- DWELL:
  - Each cycle where `pn_err[ch]|pn_oos[ch]`, increment `ch_err_cnt[ch]`, saturating at 255.
  - After exactly DWELL_CYCLES cycles, go to NEXT and set `ch_pass[ch]` = (final count == 0).
- NEXT: clear the override. If `ch`=NUM_CHANNELS-1, go to DONE; otherwise increment `ch` and go to APPLY.
- DONE: assert `done` for one cycle, then go to IDLE.
- Output mux:
  - `pn_seq_sel[i*4+:4]` = `pn_sel` when the override is active and i==`ch`.
  - Otherwise `pn_seq_sel[i*4+:4]` = `pn_seq_sel_in[i*4+:4]`.
  - The mux is combinational from registered override/`ch`. At most one channel is overridden at any time.
- `pn_sel` is sampled live. Software must hold it stable while `busy`=1.
- `start` during busy or DONE is ignored, not queued.
- Results hold their values until the next accepted start.

## Timing
- Reset values:
  - state=IDLE, `ch`=0, override=0, `busy`=0, `done`=0.
  - `ch_pass`, `ch_lock_fail`, `ch_err_cnt` all 0.
  - `pn_seq_sel` = `pn_seq_sel_in`.
- Reset mid-scan: on the next edge, all of the above apply, including override release. No `done` is generated.
- Start accepted at edge t: `busy`=1 and the channel-0 override are visible after t+1.
- For an enabled channel that locks on its first LOCK cycle, the channel costs SETTLE_CYCLES+1+DWELL_CYCLES+1 cycles (APPLY, LOCK, DWELL, NEXT).
- A lock-fail channel costs SETTLE_CYCLES+LOCK_TIMEOUT+1 cycles.
- A disabled channel costs 2 cycles (APPLY, NEXT).
- DONE lasts 1 cycle with `busy`=1 and `done`=1. `busy`=0 in the following cycle.
- The error counter samples the inputs in every DWELL cycle, including the first and last. Inputs in LOCK are not counted.

## Test plan
All scenarios use NUM_CHANNELS=4, SETTLE=4, LOCK_TIMEOUT=16, DWELL=32, `pn_sel`=4'h1.
- Clean scan: all enabled, `pn_oos`=0, `pn_err`=0, start pulse.
  - Expect `ch_pass`=4'hF, `ch_err_cnt`=0, `ch_lock_fail`=0.
  - `done` fires exactly 1+4×(4+1+32+1) cycles after start.
  - Only one channel's `pn_seq_sel` equals 1 at any cycle.
- Error counting: ch2 has `pn_err`=1 for 10 DWELL cycles; ch3 has `pn_err`=1 for all 32 cycles.
  - Expect `ch_err_cnt[2]`=10, `ch_err_cnt[3]`=32, `ch_pass`=4'h3.
- Saturation: DWELL=512 with `pn_err[0]` stuck at 1.
  - Expect `ch_err_cnt[0]`=255.
- Lock timeout: `pn_oos[1]` stuck at 1.
  - Expect `ch_lock_fail`=4'h2 and `ch_pass[1]`=0.
  - Ch1 costs exactly 4+16+1 cycles.
  - The scan continues and ch2 passes.
- Skip and ignore: `enable`=4'b1010, with a second `start` pulse mid-scan.
  - Expect disabled channels to be untouched, `pn_seq_sel[0+:4]` and `pn_seq_sel[8+:4]` never overridden, and exactly one `done`.
- Reset mid-DWELL on ch1:
  - On the next edge, `busy`=0, all results 0, and `pn_seq_sel` = `pn_seq_sel_in`.
  - A new start then completes normally.
